// File: rtl/match_pkg.sv
// -----------------------------------------------------------------------------
// match_pkg
// Shared definitions for the match controller: FSM state encodings, winner
// codes, score width and a saturating score increment helper.
// -----------------------------------------------------------------------------
package match_pkg;

  localparam int SCORE_W = 4;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_POINT    = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_t;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  // Scores stick at the maximum instead of wrapping back to zero.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] value);
    return (value == SCORE_MAX) ? value : value + 4'd1;
  endfunction

endpackage

// File: rtl/match_ctrl_pulse_sync.sv
// -----------------------------------------------------------------------------
// pulse_sync
// Brings an asynchronous level into the clk_out domain through a 2-flop
// synchroniser and emits a registered one-cycle pulse on its rising edge.
// The pulse appears 3 clk_out cycles after the raw edge is first sampled.
// Optional stability filter: when DEBOUNCE_CYCLES > 0 the synchronised level
// must differ from the accepted level for DEBOUNCE_CYCLES consecutive samples
// before it is accepted and edge-detected.
//
// Ports
//   clk_out   in   clock
//   reset     in   asynchronous, active-high reset
//   async_in  in   raw asynchronous level
//   pulse     out  one-cycle rising-edge event
// -----------------------------------------------------------------------------
module pulse_sync #(
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk_out,
  input  logic reset,
  input  logic async_in,
  output logic pulse
);

  logic       sync_a;
  logic       sync_b;
  logic       level;
  logic       level_q;
  logic       armed;
  logic [1:0] warm;

  // An input already high when reset releases must be seen low once before
  // any edge is accepted; warm marks when sync_b carries a real sample.
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      level_q <= 1'b0;
      armed   <= 1'b0;
      warm    <= 2'b00;
      pulse   <= 1'b0;
    end else begin
      sync_a  <= async_in;
      sync_b  <= sync_a;
      level_q <= level;
      warm    <= {warm[0], 1'b1};
      if (warm[1] && !sync_b) begin
        armed <= 1'b1;
      end
      pulse   <= level & ~level_q & armed;
    end
  end

  generate
    if (DEBOUNCE_CYCLES > 0) begin : g_debounce
      localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
      logic [DB_W-1:0] stable_cnt;

      always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
          level      <= 1'b0;
          stable_cnt <= '0;
        end else if (sync_b == level) begin
          stable_cnt <= '0;
        end else if (stable_cnt == DB_LAST) begin
          level      <= sync_b;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + DB_W'(1);
        end
      end
    end else begin : g_direct
      assign level = sync_b;
    end
  endgenerate

endmodule

// File: rtl/match_ctrl.sv
// -----------------------------------------------------------------------------
// match_ctrl
// Match sequencing for a two-player paddle game: waits for start, holds the
// ball for a serve delay, runs the rally, credits points, and declares a
// winner at WIN_SCORE.
// Build option: define MATCH_CTRL_START_DEBOUNCE_EN to pass the start button
// through a stability filter of DEBOUNCE_CYCLES samples.
//
// Ports
//   clk_out      in   pixel clock, sole clock
//   reset        in   asynchronous, active-high reset
//   start        in   raw push-button (async)
//   p1_point     in   player 1 scored (async)
//   p2_point     in   player 2 scored (async)
//   ball_enable  out  high only while the rally is live
//   p1_score     out  player 1 score (4-bit binary)
//   p2_score     out  player 2 score (4-bit binary)
//   game_over    out  high in GAMEOVER
//   winner       out  00 none, 01 player 1, 10 player 2
//   state_dbg    out  current FSM state encoding
// -----------------------------------------------------------------------------
module match_ctrl
  import match_pkg::*;
#(
  parameter int WIN_SCORE       = 9,
  parameter int SERVE_DELAY     = 25_175_000,
  parameter int DEBOUNCE_CYCLES = 250_000
) (
  input  logic               clk_out,
  input  logic               reset,
  input  logic               start,
  input  logic               p1_point,
  input  logic               p2_point,
  output logic               ball_enable,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               game_over,
  output logic [1:0]         winner,
  output logic [2:0]         state_dbg
);

  localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_DELAY - 1);
  localparam logic [SCORE_W-1:0] WIN_VALUE  = SCORE_W'(WIN_SCORE);

`ifdef MATCH_CTRL_START_DEBOUNCE_EN
  localparam int START_DB = DEBOUNCE_CYCLES;
`else
  // Debounce is compiled out; the parameter stays on the interface only.
  localparam int START_DB = DEBOUNCE_CYCLES * 0;
`endif

  logic start_evt;
  logic p1_evt;
  logic p2_evt;

  pulse_sync #(.DEBOUNCE_CYCLES(START_DB)) u_start_sync (
    .clk_out (clk_out),
    .reset   (reset),
    .async_in(start),
    .pulse   (start_evt)
  );

  pulse_sync #(.DEBOUNCE_CYCLES(0)) u_p1_sync (
    .clk_out (clk_out),
    .reset   (reset),
    .async_in(p1_point),
    .pulse   (p1_evt)
  );

  pulse_sync #(.DEBOUNCE_CYCLES(0)) u_p2_sync (
    .clk_out (clk_out),
    .reset   (reset),
    .async_in(p2_point),
    .pulse   (p2_evt)
  );

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   serve_cnt;
  logic [CNT_W-1:0]   serve_cnt_d;
  logic [SCORE_W-1:0] p1_score_d;
  logic [SCORE_W-1:0] p2_score_d;
  logic [SCORE_W-1:0] credited_new;
  logic [1:0]         winner_d;
  logic               credit_p2;
  logic               credit_p2_d;

  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      serve_cnt   <= '0;
      p1_score    <= '0;
      p2_score    <= '0;
      winner      <= WINNER_NONE;
      credit_p2   <= 1'b0;
      ball_enable <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state_q     <= state_d;
      serve_cnt   <= serve_cnt_d;
      p1_score    <= p1_score_d;
      p2_score    <= p2_score_d;
      winner      <= winner_d;
      credit_p2   <= credit_p2_d;
      // Registered from the next state so the ball stops the cycle PLAY ends.
      ball_enable <= (state_d == ST_PLAY);
      game_over   <= (state_d == ST_GAMEOVER);
    end
  end

  always_comb begin
    state_d      = state_q;
    serve_cnt_d  = serve_cnt;
    p1_score_d   = p1_score;
    p2_score_d   = p2_score;
    winner_d     = winner;
    credit_p2_d  = credit_p2;
    credited_new = credit_p2 ? sat_inc(p2_score) : sat_inc(p1_score);

    unique case (state_q)
      ST_IDLE: begin
        if (start_evt) begin
          state_d     = ST_SERVE;
          serve_cnt_d = '0;
        end
      end

      ST_SERVE: begin
        if (serve_cnt == SERVE_LAST) begin
          state_d     = ST_PLAY;
          serve_cnt_d = '0;
        end else begin
          serve_cnt_d = serve_cnt + CNT_W'(1);
        end
      end

      ST_PLAY: begin
        // Simultaneous points cancel out and the rally is simply re-served.
        if (p1_evt && p2_evt) begin
          state_d     = ST_SERVE;
          serve_cnt_d = '0;
        end else if (p1_evt || p2_evt) begin
          state_d     = ST_POINT;
          credit_p2_d = p2_evt;
        end
      end

      ST_POINT: begin
        if (credit_p2) begin
          p2_score_d = credited_new;
        end else begin
          p1_score_d = credited_new;
        end
        if (credited_new == WIN_VALUE) begin
          state_d  = ST_GAMEOVER;
          winner_d = credit_p2 ? WINNER_P2 : WINNER_P1;
        end else begin
          state_d     = ST_SERVE;
          serve_cnt_d = '0;
        end
      end

      ST_GAMEOVER: begin
        if (start_evt) begin
          state_d     = ST_SERVE;
          serve_cnt_d = '0;
          p1_score_d  = '0;
          p2_score_d  = '0;
          winner_d    = WINNER_NONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: doc/match_ctrl.md
MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 9: points needed to win a match (range 1..15).
REQ-002 Parameter SERVE_DELAY, default 25_175_000: clk_out cycles the ball is held before each serve.
REQ-003 Parameter DEBOUNCE_CYCLES, default 250_000: cycles start must be stable to register (START_DEBOUNCE_EN only).
REQ-004 clk_out  input  1  pixel clock, 25.175 MHz; sole clock of the block.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  raw push-button, asynchronous to clk_out.
REQ-007 p1_point  input  1  point-scored level/pulse for player 1 from ball controller, asynchronous (ball clock domain).
REQ-008 p2_point  input  1  point-scored level/pulse for player 2, asynchronous.
REQ-009 ball_enable  output  1  high only while rally is live; drives ball/paddle enable.
REQ-010 p1_score  output  4  player 1 score, binary.
REQ-011 p2_score  output  4  player 2 score, binary.
REQ-012 game_over  output  1  high while in GAMEOVER.
REQ-013 winner  output  2  00 none, 01 player 1, 10 player 2; 11 never driven.
REQ-014 state_dbg  output  3  current FSM state encoding.

Function
REQ-015 Each asynchronous input SHALL pass a 2-flop synchroniser then rising-edge detect; internal event pulse is one cycle wide, 3 clk_out cycles after the raw rising edge is first sampled.
REQ-016 FSM states: IDLE, SERVE, PLAY, POINT, GAMEOVER; all registered outputs change on clk_out rising edge.
REQ-017 IDLE: ball_enable 0; start event -> SERVE, serve counter cleared.
REQ-018 SERVE: ball_enable 0; counter increments each cycle; at count SERVE_DELAY-1 -> PLAY next cycle.
REQ-019 PLAY: ball_enable 1; exactly one point event -> POINT, credited player latched; both point events in same cycle -> SERVE, no score change.
REQ-020 POINT (one cycle): credited score increments by 1; if new value equals WIN_SCORE -> GAMEOVER with winner set, else -> SERVE.
REQ-021 Scores SHALL saturate at 15; never wrap.
REQ-022 Point events outside PLAY SHALL be ignored; start events outside IDLE/GAMEOVER SHALL be ignored.
REQ-023 GAMEOVER: ball_enable 0, game_over 1, scores and winner hold; start event -> scores and winner cleared, -> SERVE.
REQ-024 ball_enable SHALL drop in the same cycle PLAY is left (registered from next-state).

Reset
REQ-025 reset asserted: state IDLE, p1_score 0, p2_score 0, winner 00, game_over 0, ball_enable 0, counters and synchroniser flops 0; effective immediately, mid-rally included.
REQ-026 A start level held high through reset release SHALL NOT generate a start event.

Configuration
REQ-027 Macro MATCH_CTRL_START_DEBOUNCE_EN defined: synchronised start passes a stability counter; event issued only after DEBOUNCE_CYCLES consecutive equal samples, then edge-detected.
REQ-028 Macro undefined: start uses synchroniser and edge detect only (REQ-015 latency); DEBOUNCE_CYCLES unused.

Structure
REQ-029 Shared package match_pkg SHALL hold the state enum/encodings, winner codes, and score width constant (4).
REQ-030 Sub-module pulse_sync (2-flop sync + rising-edge pulse) SHALL be instantiated three times.

Verification (SERVE_DELAY=8, WIN_SCORE=3, macro undefined unless stated)
REQ-031 reset, start pulse -> SERVE 3 cycles later; ball_enable 1 exactly 8 cycles after SERVE entry.
REQ-032 In PLAY, p1_point pulse -> p1_score 1, ball_enable 0, SERVE, then PLAY again after 8 cycles.
REQ-033 Three p2_point events across rallies -> p2_score 3, game_over 1, winner 10; further point pulses leave scores unchanged.
REQ-034 p1_point and p2_point rise same cycle in PLAY -> scores unchanged, state SERVE.
REQ-035 reset asserted mid-PLAY with scores 2/1 -> all outputs at reset values without waiting for clock; start held high across release -> stays IDLE.
REQ-036 Macro defined, DEBOUNCE_CYCLES=16: 5-cycle start glitch -> no transition; 20-cycle press -> SERVE.
